mdu_sequencer: RTL and testbench

//  Multi-cycle multiply/divide unit controller for the 5-stage pipeline; sits in E stage beside the ALU.

---
 rtl/mdu_sequencer.sv | 146 ++++++++++++++
 tb/tb_mdu_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
// mdu_sequencer
//   Multiply/divide controller in the E stage. Accepts mult/multu/div/divu
//   (fixed-latency, busy for MULT_CYCLES / DIV_CYCLES) and mthi/mtlo
//   (single-cycle register writes), and owns the architectural HI/LO pair.
//
// Ports
//   clk    in   1   rising-edge clock
//   reset  in   1   synchronous, active-high
//   start  in   1   MDU instruction valid (one-cycle pulse)
//   op     in   3   000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 11x no-op
//   A, B   in   32  rs / rt operands, sampled only in the start cycle
//   busy   out  1   operation in flight, HI/LO not yet valid
//   done   out  1   pulse: HI/LO take the new result at the end of this cycle
//   HI, LO out  32  architectural HI/LO registers
module mdu_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES) + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          load;

    logic [31:0]   res_hi, res_lo;
    logic          res_wr;          // cleared for divide-by-zero: HI/LO stay untouched

    // ------------------------------------------------------------------
    // Result datapath, evaluated from the start-cycle operands
    // ------------------------------------------------------------------
    logic [63:0]   ext_a, ext_b, prod;
    logic          sdiv, a_neg, b_neg;
    logic [31:0]   a_mag, b_mag, b_div, uq, ur, quo, rem;
    logic [31:0]   calc_hi, calc_lo;

    always_comb begin
        // Sign- or zero-extend to 64 bits; the low 64 bits of the product
        // are then correct for both signed and unsigned multiply.
        ext_a = op[0] ? {32'd0, A} : {{32{A[31]}}, A};
        ext_b = op[0] ? {32'd0, B} : {{32{B[31]}}, B};
        prod  = ext_a * ext_b;

        // One unsigned divider shared by div/divu: signed divide runs on
        // magnitudes and re-applies signs. 0x80000000 / -1 falls out as
        // 0x80000000 with remainder 0 because the magnitude wraps.
        sdiv  = ~op[0];
        a_neg = sdiv & A[31];
        b_neg = sdiv & B[31];
        a_mag = a_neg ? (32'd0 - A) : A;
        b_mag = b_neg ? (32'd0 - B) : B;
        b_div = (B == 32'd0) ? 32'd1 : b_mag;   // result discarded when B==0
        uq    = a_mag / b_div;
        ur    = a_mag % b_div;
        quo   = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
        rem   = a_neg ? (32'd0 - ur) : ur;

        if (op[1]) begin
            calc_hi = rem;
            calc_lo = quo;
        end else begin
            calc_hi = prod[63:32];
            calc_lo = prod[31:0];
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy      = 1'b0;
        done      = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (start && !op[2]) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                    cnt_nxt   = op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                end
            end
            RUN: begin
                // start is ignored here; the in-flight op always completes
                busy    = 1'b1;
                cnt_nxt = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Result latch and HI/LO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            res_hi <= '0;
            res_lo <= '0;
            res_wr <= 1'b0;
            HI     <= '0;
            LO     <= '0;
        end else begin
            if (load) begin
                res_hi <= calc_hi;
                res_lo <= calc_lo;
                res_wr <= !(op[1] && B == 32'd0);
            end
            if (done && res_wr) begin
                HI <= res_hi;
                LO <= res_lo;
            end
            if (state == IDLE && start && op == 3'b100) HI <= A;
            if (state == IDLE && start && op == 3'b101) LO <= A;
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
module tb_mdu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;

    int npass  = 0;
    int ntotal = 0;

    // reference HI/LO state
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mdu_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(a), .B(b),
        .busy(busy), .done(done), .HI(hi), .LO(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Architectural effect of one instruction on {HI,LO}, in 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, y,
                                          input logic [31:0] h, l);
        longint      sx, sy, q, r;
        logic [63:0] res;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        res = {h, l};
        case (o)
            3'd0: res = sx * sy;
            3'd1: res = {32'd0, x} * {32'd0, y};
            3'd2: if (y != 0) begin
                      q   = sx / sy;
                      r   = sx % sy;
                      res = {32'(r), 32'(q)};
                  end
            3'd3: if (y != 0) res = {x % y, x / y};
            3'd4: res = {x, l};
            3'd5: res = {h, x};
            default: ;
        endcase
        return res;
    endfunction

    function automatic int latency(input logic [2:0] o);
        return o[1] ? 10 : 5;
    endfunction

    // Issue an arithmetic op starting now (start is sampled at the next
    // rising edge), then observe busy/done each cycle until one cycle past
    // done. Pure observation; comparisons are made by the calling test.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a_in, b_in,
                          output logic b0, output int nbusy, output int done_at,
                          output int ndone, output logic [31:0] hi_o, lo_o,
                          output logic busy_after, output logic to);
        b0 = 1'b0; nbusy = 0; done_at = 0; ndone = 0;
        hi_o = '0; lo_o = '0; busy_after = 1'b1; to = 1'b1;
        start = 1'b1; op = o; a = a_in; b = b_in;
        #1 b0 = busy | done;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom;   // must not affect the result
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                if (done_at == 0) done_at = c;
            end
            if (done_at != 0 && c == done_at + 1) begin
                hi_o = hi; lo_o = lo; busy_after = busy; to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        ntotal++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else npass++;
        ntotal++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else npass++;
        ntotal++; if (hi !== 32'd0) $display("FAIL reset_hi: got %h expected 0", hi); else npass++;
        ntotal++; if (lo !== 32'd0) $display("FAIL reset_lo: got %h expected 0", lo); else npass++;
        reset = 1'b0;
        m_hi = 0; m_lo = 0;
    endtask

    task automatic test_mult;
        logic b0, ba, to; int nb, da, nd; logic [31:0] h, l;
        run_op(3'd0, 32'hFFFFFFFE, 32'd3, b0, nb, da, nd, h, l, ba, to);
        ntotal++;
        if (to || b0 !== 1'b0 || nb != 5 || da != 5 || nd != 1 || ba !== 1'b0)
            $display("FAIL mult_timing: got to=%0b b0=%0b busy=%0d done_at=%0d ndone=%0d busy_after=%0b expected 0/0/5/5/1/0",
                     to, b0, nb, da, nd, ba);
        else npass++;
        ntotal++; if (h !== 32'hFFFFFFFF) $display("FAIL mult_hi: got %h expected ffffffff", h); else npass++;
        ntotal++; if (l !== 32'hFFFFFFFA) $display("FAIL mult_lo: got %h expected fffffffa", l); else npass++;
        m_hi = h; m_lo = l;
    endtask

    task automatic test_multu_div;
        logic b0, ba, to; int nb, da, nd; logic [31:0] h, l;
        run_op(3'd1, 32'hFFFFFFFF, 32'd2, b0, nb, da, nd, h, l, ba, to);
        ntotal++;
        if (to || nb != 5 || da != 5 || ba !== 1'b0)
            $display("FAIL multu_timing: got to=%0b busy=%0d done_at=%0d expected 0/5/5", to, nb, da);
        else npass++;
        ntotal++;
        if (h !== 32'h1 || l !== 32'hFFFFFFFE)
            $display("FAIL multu_result: got %h_%h expected 00000001_fffffffe", h, l);
        else npass++;
        run_op(3'd2, 32'hFFFFFFF9, 32'd2, b0, nb, da, nd, h, l, ba, to);
        ntotal++;
        if (to || b0 !== 1'b0 || nb != 10 || da != 10 || nd != 1 || ba !== 1'b0)
            $display("FAIL div_timing: got to=%0b busy=%0d done_at=%0d ndone=%0d expected 0/10/10/1", to, nb, da, nd);
        else npass++;
        ntotal++;
        if (h !== 32'hFFFFFFFF || l !== 32'hFFFFFFFD)
            $display("FAIL div_result: got %h_%h expected ffffffff_fffffffd", h, l);
        else npass++;
        m_hi = h; m_lo = l;
    endtask

    task automatic test_div_zero;
        logic b0, ba, to; int nb, da, nd; logic [31:0] h, l;
        start = 1'b1; op = 3'd4; a = 32'h11;
        @(posedge clk); #1;
        op = 3'd5; a = 32'h22;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        ntotal++;
        if (hi !== 32'h11 || lo !== 32'h22)
            $display("FAIL mt_preset: got %h_%h expected 00000011_00000022", hi, lo);
        else npass++;
        run_op(3'd3, 32'd100, 32'd0, b0, nb, da, nd, h, l, ba, to);
        ntotal++;
        if (to || nb != 10 || da != 10 || nd != 1 || ba !== 1'b0)
            $display("FAIL divzero_timing: got to=%0b busy=%0d done_at=%0d ndone=%0d expected 0/10/10/1", to, nb, da, nd);
        else npass++;
        ntotal++;
        if (h !== 32'h11 || l !== 32'h22)
            $display("FAIL divzero_result: got %h_%h expected 00000011_00000022", h, l);
        else npass++;
        m_hi = 32'h11; m_lo = 32'h22;
    endtask

    task automatic test_mthi_and_ignore;
        logic saw_busy; int done_at; logic [31:0] h, l;
        start = 1'b1; op = 3'd4; a = 32'hDEADBEEF;
        #1 saw_busy = busy | done;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        saw_busy = saw_busy | busy | done;
        ntotal++;
        if (hi !== 32'hDEADBEEF || lo !== m_lo || saw_busy)
            $display("FAIL mthi: got hi=%h lo=%h busy/done=%0b expected hi=deadbeef lo=%h 0", hi, lo, saw_busy, m_lo);
        else npass++;
        m_hi = 32'hDEADBEEF;
        // mult 7*9, then an mtlo issued in busy cycle 2 must be dropped
        start = 1'b1; op = 3'd0; a = 32'd7; b = 32'd9;
        @(posedge clk); #1; start = 1'b0;          // cycle 1
        @(posedge clk); #1;                        // cycle 2
        start = 1'b1; op = 3'd5; a = 32'd5;
        @(posedge clk); #1; start = 1'b0;          // cycle 3
        done_at = 0; h = '0; l = '0;
        for (int c = 3; c <= 40; c++) begin
            @(negedge clk);
            if (done && done_at == 0) done_at = c;
            if (done_at != 0 && c == done_at + 1) begin h = hi; l = lo; break; end
        end
        ntotal++;
        if (done_at != 5 || h !== 32'd0 || l !== 32'd63)
            $display("FAIL start_ignored: got done_at=%0d hi=%h lo=%h expected 5 00000000 0000003f", done_at, h, l);
        else npass++;
        m_hi = 0; m_lo = 63;
    endtask

    task automatic test_back_to_back;
        logic b0, ba, to; int nb, da, nd; logic [31:0] h, l;
        run_op(3'd1, 32'd1000, 32'd3000, b0, nb, da, nd, h, l, ba, to);
        // this call begins in the cycle right after the previous done
        run_op(3'd0, 32'hFFFFFFFF, 32'h7FFFFFFF, b0, nb, da, nd, h, l, ba, to);
        ntotal++;
        if (to || b0 !== 1'b0 || nb != 5 || da != 5 || ba !== 1'b0)
            $display("FAIL b2b_timing: got to=%0b b0=%0b busy=%0d done_at=%0d expected 0/0/5/5", to, b0, nb, da);
        else npass++;
        ntotal++;
        if (h !== 32'hFFFFFFFF || l !== 32'h80000001)
            $display("FAIL b2b_result: got %h_%h expected ffffffff_80000001", h, l);
        else npass++;
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, b0, nb, da, nd, h, l, ba, to);
        ntotal++;
        if (to || nb != 10 || da != 10 || h !== 32'd0 || l !== 32'h80000000)
            $display("FAIL div_overflow: got to=%0b busy=%0d hi=%h lo=%h expected 0/10 00000000 80000000", to, nb, h, l);
        else npass++;
        m_hi = h; m_lo = l;
    endtask

    task automatic test_reset_mid;
        logic b0, ba, to; int nb, da, nd, late_done; logic [31:0] h, l; logic [63:0] e;
        start = 1'b1; op = 3'd2; a = 32'd1000; b = 32'd7;
        @(posedge clk); #1; start = 1'b0;
        repeat (3) @(negedge clk);                 // now in busy cycle 3
        ntotal++; if (busy !== 1'b1) $display("FAIL midrun_busy: got %b expected 1", busy); else npass++;
        reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        ntotal++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0)
            $display("FAIL reset_abort: got busy=%b done=%b hi=%h lo=%h expected 0 0 0 0", busy, done, hi, lo);
        else npass++;
        m_hi = 0; m_lo = 0;
        late_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) late_done++;
        end
        ntotal++;
        if (late_done != 0 || hi !== 32'd0 || lo !== 32'd0)
            $display("FAIL reset_discard: got activity=%0d hi=%h lo=%h expected 0 0 0", late_done, hi, lo);
        else npass++;
        run_op(3'd0, 32'd12345, 32'hFFFFFF00, b0, nb, da, nd, h, l, ba, to);
        e = model(3'd0, 32'd12345, 32'hFFFFFF00, m_hi, m_lo);
        ntotal++;
        if (to || nb != 5 || da != 5 || {h, l} !== e)
            $display("FAIL post_reset_mult: got to=%0b busy=%0d result=%h expected 0/5 %h", to, nb, {h, l}, e);
        else npass++;
        {m_hi, m_lo} = e;
    endtask

    task automatic test_random;
        logic b0, ba, to, act; int nb, da, nd; logic [31:0] h, l, x, y; logic [2:0] o; logic [63:0] e;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            x = $urandom;
            y = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) y = y & 32'hF;
            e = model(o, x, y, m_hi, m_lo);
            if (!o[2]) begin
                run_op(o, x, y, b0, nb, da, nd, h, l, ba, to);
                ntotal++;
                if (to || b0 !== 1'b0 || nb != latency(o) || da != latency(o) || nd != 1 || ba !== 1'b0 || {h, l} !== e)
                    $display("FAIL rand_%0d op=%0d a=%h b=%h: got to=%0b busy=%0d done_at=%0d result=%h expected busy=%0d %h",
                             i, o, x, y, to, nb, da, {h, l}, latency(o), e);
                else npass++;
            end else begin
                start = 1'b1; op = o; a = x; b = y;
                #1 act = busy | done;
                @(posedge clk); #1; start = 1'b0;
                @(negedge clk);
                act = act | busy | done;
                ntotal++;
                if (act || {hi, lo} !== e)
                    $display("FAIL rand_%0d op=%0d a=%h: got busy/done=%0b result=%h expected 0 %h", i, o, x, act, {hi, lo}, e);
                else npass++;
            end
            {m_hi, m_lo} = e;
        end
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_mult();
        test_multu_div();
        test_div_zero();
        test_mthi_and_ignore();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
